uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter byte channel between N_REQ independent byte-stream requesters, e.g. a status reporter, a debug echo and a command responder.
- Each requester sends packets as valid/ready byte streams, with a last flag marking the final byte.
- The arbiter grants one requester at a time, round-robin, and holds the grant for a whole packet.
- The grant is revoked early on a stall timeout or when the packet exceeds a byte limit.
- The block sits between the requesters and the UART TX serializer, on the clk_50 domain.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N requesters, the arbiter and the UART TX serializer.
// master: requester/serializer side; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned DATA_BITS = 8
);
  logic [N_REQ*DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_last;
  logic [N_REQ-1:0]           req_ready;
  logic [DATA_BITS-1:0]       tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic [N_REQ-1:0]           grant;
  logic                       busy;
  logic                       timeout_err;
  logic                       trunc_err;

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy, timeout_err, trunc_err
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy, timeout_err, trunc_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX byte channel between N_REQ
// requesters, with stall-timeout and packet-length revocation of the grant.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 3,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned TIMEOUT_CLKS  = 50000,
  parameter int unsigned MAX_PKT_BYTES = 64
) (
  input logic              clk_50,
  input logic              reset,
  uart_tx_arbiter_if.slave arb_io
);
  localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned StallW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int unsigned ByteW  = (MAX_PKT_BYTES > 1) ? $clog2(MAX_PKT_BYTES) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  localparam logic [StallW-1:0] StallLast = StallW'(TIMEOUT_CLKS - 1);
  localparam logic [ByteW-1:0]  ByteLast  = ByteW'(MAX_PKT_BYTES - 1);
  localparam logic [IdxW-1:0]   PtrInit   = IdxW'(N_REQ - 1);

  logic [0:0]          state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [ByteW-1:0]    byte_cnt_q, byte_cnt_d;
  logic                timeout_q, timeout_d;
  logic                trunc_q, trunc_d;

  logic [DATA_BITS-1:0] req_bytes [N_REQ];
  logic [IdxW-1:0]      winner;
  logic [IdxW-1:0]      cand;
  logic                 any_req;
  logic                 xfer;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 hs;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_bytes[i] = arb_io.req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Cyclic search starting one past the last owner.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!any_req && arb_io.req_valid[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign xfer        = (state_q == StXfer);
  assign owner_valid = xfer & arb_io.req_valid[owner_q];
  assign owner_last  = arb_io.req_last[owner_q];
  assign hs          = owner_valid & arb_io.tx_ready;

  assign arb_io.grant       = grant_q;
  assign arb_io.busy        = xfer;
  assign arb_io.tx_valid    = owner_valid;
  assign arb_io.tx_data     = xfer ? req_bytes[owner_q] : '0;
  assign arb_io.req_ready   = grant_q & {N_REQ{arb_io.tx_ready}};
  assign arb_io.timeout_err = timeout_q;
  assign arb_io.trunc_err   = trunc_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    stall_cnt_d = stall_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    timeout_d   = 1'b0;
    trunc_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d     = StXfer;
          owner_d     = winner;
          grant_d     = N_REQ'(1) << winner;
          stall_cnt_d = '0;
          byte_cnt_d  = '0;
        end
      end
      StXfer: begin
        if (hs) begin
          stall_cnt_d = '0;
          if (owner_last || byte_cnt_q == ByteLast) begin
            // A last byte that also hits the limit ends the packet normally.
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = owner_q;
            trunc_d  = ~owner_last;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (!owner_valid) begin
          if (stall_cnt_q == StallLast) begin
            state_d   = StIdle;
            grant_d   = '0;
            rr_ptr_d  = owner_q;
            timeout_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= PtrInit;
      grant_q     <= '0;
      stall_cnt_q <= '0;
      byte_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      stall_cnt_q <= stall_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      timeout_q   <= timeout_d;
      trunc_q     <= trunc_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues plus a packet-level
// arbitration model checked by a negedge monitor.
module tb_uart_tx_arbiter;
  localparam int NReq        = 3;
  localparam int DBits       = 8;
  localparam int TimeoutClks = 16;
  localparam int MaxPkt      = 4;

  typedef struct {
    logic [7:0] data;
    bit         last;
    int         gap;
  } beat_t;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_50 = ~clk_50;

  uart_tx_arbiter_if #(.N_REQ(NReq), .DATA_BITS(DBits)) bus ();

  uart_tx_arbiter #(
    .N_REQ        (NReq),
    .DATA_BITS    (DBits),
    .TIMEOUT_CLKS (TimeoutClks),
    .MAX_PKT_BYTES(MaxPkt)
  ) dut (
    .clk_50(clk_50),
    .reset (reset),
    .arb_io(bus)
  );

  beat_t      drv_q [NReq][$];
  logic [7:0] sb_q  [NReq][$];
  int         gap_cnt [NReq];
  bit         rdy_q [$];
  bit         rdy_rand;

  int checks   = 0;
  int failures = 0;
  int to_cnt   = 0;
  int tr_cnt   = 0;
  int xfer_cnt = 0;

  function automatic void check_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit bit_of(logic [NReq-1:0] v, int i);
    return ((v >> i) & NReq'(1)) != '0;
  endfunction

  function automatic logic [7:0] byte_of(int i);
    return 8'(bus.req_data >> (8 * i));
  endfunction

  function automatic int first_from(int base, logic [NReq-1:0] v);
    for (int k = 1; k <= NReq; k++) begin
      if (bit_of(v, (base + k) % NReq)) return (base + k) % NReq;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(logic [NReq-1:0] g);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < NReq; i++) begin
      if (bit_of(g, i)) begin
        n++;
        idx = i;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic push_beat(int r, logic [7:0] d, bit last, int gap);
    beat_t b;
    b.data = d;
    b.last = last;
    b.gap  = gap;
    drv_q[r].push_back(b);
    sb_q[r].push_back(d);
  endtask

  // One clock of requester/serializer stimulus, updated just after the edge.
  task automatic step();
    bit acc [NReq];
    logic [NReq-1:0]       nv;
    logic [NReq-1:0]       nl;
    logic [NReq*DBits-1:0] nd;
    @(negedge clk_50);
    for (int i = 0; i < NReq; i++) acc[i] = bit_of(bus.req_valid, i) && bit_of(bus.req_ready, i);
    @(posedge clk_50);
    #1;
    nv = '0;
    nl = '0;
    nd = '0;
    for (int i = 0; i < NReq; i++) begin
      if (acc[i] && drv_q[i].size() > 0) begin
        void'(drv_q[i].pop_front());
        gap_cnt[i] = 0;
      end
      if (drv_q[i].size() > 0 && gap_cnt[i] >= drv_q[i][0].gap) begin
        nv |= NReq'(1) << i;
        if (drv_q[i][0].last) nl |= NReq'(1) << i;
        nd |= (NReq*DBits)'(drv_q[i][0].data) << (DBits * i);
      end else if (drv_q[i].size() > 0) begin
        gap_cnt[i]++;
      end
    end
    bus.req_valid = nv;
    bus.req_last  = nl;
    bus.req_data  = nd;
    if (rdy_q.size() > 0) bus.tx_ready = rdy_q.pop_front();
    else if (rdy_rand)    bus.tx_ready = ($urandom_range(0, 3) != 0);
    else                  bus.tx_ready = 1'b1;
  endtask

  function automatic bit drv_empty();
    for (int i = 0; i < NReq; i++) if (drv_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (n < budget && !(drv_empty() && !bus.busy)) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: not idle after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: packet-level model of grant ownership, revocation and byte order.
  logic [NReq-1:0] m_g;
  logic [NReq-1:0] m_exp_grant;
  bit              m_exp_to;
  bit              m_exp_tr;
  int              m_bytes;
  int              m_stall;
  int              m_last_owner;
  int              m_o;
  int              m_w;
  logic [7:0]      m_exp_b;

  always @(negedge clk_50) begin
    if (!reset) begin
      m_exp_grant  = '0;
      m_exp_to     = 1'b0;
      m_exp_tr     = 1'b0;
      m_bytes      = 0;
      m_stall      = 0;
      m_last_owner = NReq - 1;
    end else begin
      m_g = bus.grant;
      check_eq("grant", 32'(m_g), 32'(m_exp_grant));
      check_eq("timeout_err", 32'(bus.timeout_err), 32'(m_exp_to));
      check_eq("trunc_err", 32'(bus.trunc_err), 32'(m_exp_tr));
      check_eq("busy", 32'(bus.busy), 32'(m_g != '0));
      if (bus.timeout_err) to_cnt++;
      if (bus.trunc_err) tr_cnt++;
      m_o = onehot_idx(m_g);
      if (m_o < 0) begin
        check_eq("idle tx_valid", 32'(bus.tx_valid), 32'(0));
        check_eq("idle req_ready", 32'(bus.req_ready), 32'(0));
      end else begin
        check_eq("tx_valid", 32'(bus.tx_valid), 32'(bit_of(bus.req_valid, m_o)));
        check_eq("req_ready", 32'(bus.req_ready), 32'(m_g & {NReq{bus.tx_ready}}));
        if (bus.tx_valid) check_eq("tx_data path", 32'(bus.tx_data), 32'(byte_of(m_o)));
      end
      m_exp_to = 1'b0;
      m_exp_tr = 1'b0;
      if (m_o < 0) begin
        m_w         = first_from(m_last_owner, bus.req_valid);
        m_exp_grant = (m_w < 0) ? '0 : NReq'(1) << m_w;
        m_bytes     = 0;
        m_stall     = 0;
      end else begin
        m_exp_grant = m_g;
        if (bus.tx_valid && bus.tx_ready) begin
          xfer_cnt++;
          if (sb_q[m_o].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx byte: got 0x%0h from req %0d, expected no byte", bus.tx_data, m_o);
          end else begin
            m_exp_b = sb_q[m_o].pop_front();
            check_eq("tx byte", 32'(bus.tx_data), 32'(m_exp_b));
          end
          m_stall = 0;
          if (bit_of(bus.req_last, m_o)) begin
            m_exp_grant  = '0;
            m_last_owner = m_o;
          end else begin
            m_bytes++;
            if (m_bytes == MaxPkt) begin
              m_exp_grant  = '0;
              m_exp_tr     = 1'b1;
              m_last_owner = m_o;
            end
          end
        end else if (!bit_of(bus.req_valid, m_o)) begin
          m_stall++;
          if (m_stall == TimeoutClks) begin
            m_exp_grant  = '0;
            m_exp_to     = 1'b1;
            m_last_owner = m_o;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int r, len, base_to, base_tr, base_x, n;
    bus.req_data  = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    rdy_rand      = 1'b0;
    for (int i = 0; i < NReq; i++) gap_cnt[i] = 0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    check_eq("reset grant", 32'(bus.grant), 32'(0));
    check_eq("reset busy", 32'(bus.busy), 32'(0));
    check_eq("reset tx_valid", 32'(bus.tx_valid), 32'(0));
    check_eq("reset req_ready", 32'(bus.req_ready), 32'(0));
    check_eq("reset timeout_err", 32'(bus.timeout_err), 32'(0));
    check_eq("reset trunc_err", 32'(bus.trunc_err), 32'(0));
    reset        = 1'b1;
    bus.tx_ready = 1'b1;

    // Single requester, 3-byte packet.
    push_beat(1, 8'h11, 1'b0, 0);
    push_beat(1, 8'h22, 1'b0, 0);
    push_beat(1, 8'h33, 1'b1, 0);
    wait_idle("single", 100);
    check_eq("single bytes", 32'(xfer_cnt), 32'(3));

    // Simultaneous 2-byte packets from everyone, fresh round-robin pointer.
    do_reset();
    for (int i = 0; i < NReq; i++) begin
      push_beat(i, 8'(8'hA0 + 16 * i), 1'b0, 0);
      push_beat(i, 8'(8'hA1 + 16 * i), 1'b1, 0);
    end
    wait_idle("simultaneous", 100);

    // Backpressure on req 2.
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    push_beat(2, 8'hA3, 1'b0, 0);
    push_beat(2, 8'h55, 1'b1, 0);
    wait_idle("backpressure", 100);

    // Stall timeout: req 0 stops mid-packet while req 1 waits.
    base_to = to_cnt;
    push_beat(0, 8'h01, 1'b0, 0);
    push_beat(0, 8'h02, 1'b1, 30);
    push_beat(1, 8'hB1, 1'b0, 0);
    push_beat(1, 8'hB2, 1'b1, 0);
    wait_idle("timeout", 300);
    check_eq("timeout pulses", 32'(to_cnt - base_to), 32'(1));

    // Truncation: 6 unterminated bytes, then a terminated tail.
    base_tr = tr_cnt;
    for (int i = 0; i < 6; i++) push_beat(1, 8'(8'hC0 + i), 1'b0, 0);
    push_beat(1, 8'hC6, 1'b0, 0);
    push_beat(1, 8'hC7, 1'b1, 0);
    wait_idle("truncation", 200);
    check_eq("trunc pulses", 32'(tr_cnt - base_tr), 32'(1));

    // Randomised traffic within the length and stall limits.
    base_to  = to_cnt;
    base_tr  = tr_cnt;
    rdy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      r   = $urandom_range(0, NReq - 1);
      len = $urandom_range(1, MaxPkt);
      for (int b = 0; b < len; b++) push_beat(r, 8'($urandom), b == len - 1, $urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) step();
    end
    wait_idle("random", 4000);
    rdy_rand = 1'b0;
    check_eq("random timeout pulses", 32'(to_cnt - base_to), 32'(0));
    check_eq("random trunc pulses", 32'(tr_cnt - base_tr), 32'(0));

    // Asynchronous reset during byte 2 of a 4-byte packet.
    for (int i = 0; i < 4; i++) push_beat(2, 8'(8'hD0 + i), i == 3, 0);
    base_x = xfer_cnt;
    n = 0;
    while (xfer_cnt - base_x < 1 && n < 100) begin
      step();
      n++;
    end
    check_eq("midpkt first byte seen", 32'(xfer_cnt - base_x), 32'(1));
    #2 reset = 1'b0;
    #1;
    check_eq("async grant", 32'(bus.grant), 32'(0));
    check_eq("async tx_valid", 32'(bus.tx_valid), 32'(0));
    check_eq("async req_ready", 32'(bus.req_ready), 32'(0));
    check_eq("async busy", 32'(bus.busy), 32'(0));
    for (int i = 0; i < NReq; i++) begin
      drv_q[i].delete();
      sb_q[i].delete();
      gap_cnt[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    repeat (2) @(posedge clk_50);
    #1 reset = 1'b1;
    for (int i = 0; i < NReq; i++) push_beat(i, 8'(8'hE0 + i), 1'b1, 0);
    step();
    step();
    check_eq("post-reset winner", 32'(bus.grant), 32'(1));
    wait_idle("post-reset", 100);

    for (int i = 0; i < NReq; i++) check_eq("leftover bytes", 32'(sb_q[i].size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
